alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

ID/EX operand stage of the pipelined MIPS datapath, immediately upstream of the ALU. Registers decoded instruction fields from decode, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's `portA`, `portB` and `aluOp` inputs. It also supplies the destination and store-data fields that travel alongside the ALU result. Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
- No parameters. `word_t` = 32 bits, `aluop_t` = 4 bits, register index = 5 bits (from `cpu_types_pkg`).
- `CLK  in  1  system clock, rising edge`
- `RST  in  1  synchronous, active-high reset`
- `en  in  1  1 = load new decode fields; 0 = stall (hold, with refresh)`
- `flush  in  1  insert bubble on next edge`
- `in_valid  in  1  decode slot holds a real instruction`
- `in_rs, in_rt, in_rd  in  5 each  source/destination register indices`
- `in_rs_data, in_rt_data  in  32 each  register-file read data`
- `in_imm  in  32  immediate, already sign/zero extended by decode`
- `in_shamt  in  5  shift amount`
- `in_alusrc  in  1  1 = portB takes imm`
- `in_shift  in  1  1 = portA takes zero-extended shamt`
- `in_aluop  in  4  ALU operation`
- `in_regwen  in  1  instruction writes rd`
- `exm_regwen, exm_rd, exm_data  in  1/5/32  EX/MEM forwarding source`
- `mwb_regwen, mwb_rd, mwb_data  in  1/5/32  MEM/WB forwarding source`
- `portA, portB  out  32 each  ALU operands`
- `aluOp  out  4  ALU operation`
- `out_valid, out_rd, out_regwen  out  1/5/1  fields forwarded downstream`
- `out_store_data  out  32  forwarded rt value for stores`

## Operation
- State register holds: valid, rs, rt, rd, rs_data, rt_data, imm, shamt, alusrc, shift, aluop, regwen.
- Forwarded value fwd(r, d):
  - if r ≠ 0, exm_regwen and exm_rd = r: exm_data;
  - else if r ≠ 0, mwb_regwen and mwb_rd = r: mwb_data;
  - else d.
  - EX/MEM has priority. Register 0 is never forwarded.
- rsv = fwd(rs, rs_data); rtv = fwd(rt, rt_data). Both are combinational from state plus the current forwarding inputs.
- `portA` = shift ? {27'b0, shamt} : rsv.
- `portB` = alusrc ? imm : rtv.
- `out_store_data` = rtv. `aluOp` = stored aluop.
- `out_regwen` = regwen AND valid. A bubble never writes.
- Priority per edge: RST > flush > en.
  - RST or flush: all state fields to 0. A bubble is equivalent to `sll $0,$0,0` with valid = 0.
  - en = 1: load all `in_*` fields.
  - en = 0 (stall): hold all fields, except rs_data := rsv and rt_data := rtv. This refresh captures forwarded values before their producers retire, so the operands stay correct across multi-cycle stalls.
- The block never generates a stall itself; load-use detection belongs to the hazard unit.

## Timing
- 1-cycle latency: fields presented with en = 1 at edge N appear on outputs after edge N.
- Forwarding is zero-latency. Output changes follow exm/mwb inputs within the same cycle.
- Reset values: `portA` = 0, `portB` = 0, `aluOp` = 0, `out_valid` = 0, `out_rd` = 0, `out_regwen` = 0, `out_store_data` = 0. These hold until the first non-reset edge.
- flush and en both high: flush wins and the incoming instruction is dropped.
- RST asserted mid-stall: state clears on that edge and any pending refresh is discarded.
- exm and mwb both match the same r: exm_data is used.
- A matching exm_rd with exm_regwen = 0 is ignored, and the MEM/WB or register value is used.

## Test plan
- **Reset:** assert RST with in_valid = 1, en = 1, in_aluop = 4'h3 -> after the edge all outputs = 0. After release and one en edge, `aluOp` = 3.
- **Basic pass, no forwarding:** rs = 8, rs_data = 32'h10, alusrc = 1, imm = 32'hFFFF_FFFC, no matches -> portA = 32'h10, portB = 32'hFFFF_FFFC one cycle later.
- **Forward priority:** stored rs = rt = 9; exm_rd = 9/regwen = 1/data = 32'hAAAA; mwb_rd = 9/data = 32'hBBBB -> portA = portB = out_store_data = 32'hAAAA. Drop exm_regwen -> all become 32'hBBBB the same cycle.
- **Register 0:** rs = 0, exm_rd = 0, exm_regwen = 1, data = 32'h1234 -> portA = stored rs_data (0), not 32'h1234.
- **Stall refresh:** rt = 5 with stale rt_data = 0; en = 0 for 3 cycles. Cycle 1: mwb supplies rt = 5 with 32'h77, then mwb_regwen drops -> portB stays 32'h77 on cycles 2–3.
- **Flush vs enable:** flush = 1 and en = 1 on the same edge with in_valid = 1, in_regwen = 1 -> out_valid = 0, out_regwen = 0, aluOp = 0, portA = portB = 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage with EX/MEM and MEM/WB forwarding
//
// Purpose: registers decoded instruction fields, resolves RAW hazards by
// forwarding from EX/MEM (priority) and MEM/WB, and drives the ALU operands.
// Supports stall (en = 0, hold with operand refresh) and flush (bubble).
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   en, flush                 load enable / bubble insert (RST > flush > en)
//   in_*                      decoded instruction fields from decode
//   exm_regwen/rd/data        EX/MEM forwarding source
//   mwb_regwen/rd/data        MEM/WB forwarding source
//   portA, portB, aluOp       ALU inputs
//   out_valid, out_rd,
//   out_regwen, out_store_data  fields travelling with the ALU result
module alu_operand_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        en,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_shamt,
    input  logic        in_alusrc,
    input  logic        in_shift,
    input  logic [3:0]  in_aluop,
    input  logic        in_regwen,
    input  logic        exm_regwen,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_data,
    input  logic        mwb_regwen,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_data,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluOp,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic        out_regwen,
    output logic [31:0] out_store_data
);

    logic        valid_q,   valid_d;
    logic [4:0]  rs_q,      rs_d;
    logic [4:0]  rt_q,      rt_d;
    logic [4:0]  rd_q,      rd_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] imm_q,     imm_d;
    logic [4:0]  shamt_q,   shamt_d;
    logic        alusrc_q,  alusrc_d;
    logic        shift_q,   shift_d;
    logic [3:0]  aluop_q,   aluop_d;
    logic        regwen_q,  regwen_d;

    logic [31:0] rsv;
    logic [31:0] rtv;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    // Register 0 is hardwired to zero and must never be forwarded.
    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] d,
        input logic        e_wen,
        input logic [4:0]  e_rd,
        input logic [31:0] e_data,
        input logic        m_wen,
        input logic [4:0]  m_rd,
        input logic [31:0] m_data
    );
        if (r != 5'd0 && e_wen && e_rd == r) begin
            return e_data;
        end else if (r != 5'd0 && m_wen && m_rd == r) begin
            return m_data;
        end else begin
            return d;
        end
    endfunction

    always_comb begin
        rsv = fwd(rs_q, rs_data_q, exm_regwen, exm_rd, exm_data,
                  mwb_regwen, mwb_rd, mwb_data);
        rtv = fwd(rt_q, rt_data_q, exm_regwen, exm_rd, exm_data,
                  mwb_regwen, mwb_rd, mwb_data);
    end

    always_comb begin
        // Stall: hold everything, but capture forwarded operands so they
        // survive after their producers retire out of EX/MEM and MEM/WB.
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rsv;
        rt_data_d = rtv;
        imm_d     = imm_q;
        shamt_d   = shamt_q;
        alusrc_d  = alusrc_q;
        shift_d   = shift_q;
        aluop_d   = aluop_q;
        regwen_d  = regwen_q;
        if (en) begin
            valid_d   = in_valid;
            rs_d      = in_rs;
            rt_d      = in_rt;
            rd_d      = in_rd;
            rs_data_d = in_rs_data;
            rt_data_d = in_rt_data;
            imm_d     = in_imm;
            shamt_d   = in_shamt;
            alusrc_d  = in_alusrc;
            shift_d   = in_shift;
            aluop_d   = in_aluop;
            regwen_d  = in_regwen;
        end
    end

    // Reset and flush both produce an all-zero bubble (sll $0,$0,0, invalid).
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            valid_q   <= 1'b0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            imm_q     <= 32'd0;
            shamt_q   <= 5'd0;
            alusrc_q  <= 1'b0;
            shift_q   <= 1'b0;
            aluop_q   <= 4'd0;
            regwen_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            shamt_q   <= shamt_d;
            alusrc_q  <= alusrc_d;
            shift_q   <= shift_d;
            aluop_q   <= aluop_d;
            regwen_q  <= regwen_d;
        end
    end

    always_comb begin
        portA          = shift_q ? {27'd0, shamt_q} : rsv;
        portB          = alusrc_q ? imm_q : rtv;
        aluOp          = aluop_q;
        out_valid      = valid_q;
        out_rd         = rd_q;
        out_regwen     = regwen_q & valid_q;
        out_store_data = rtv;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    logic        CLK = 1'b0;
    logic        RST, en, flush, in_valid;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [31:0] in_rs_data, in_rt_data, in_imm;
    logic        in_alusrc, in_shift, in_regwen;
    logic [3:0]  in_aluop;
    logic        exm_regwen, mwb_regwen;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_data, mwb_data;
    logic [31:0] portA, portB, out_store_data;
    logic [3:0]  aluOp;
    logic        out_valid, out_regwen;
    logic [4:0]  out_rd;

    int errors = 0;
    int checks = 0;

    alu_operand_stage dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in_valid(in_valid),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_alusrc(in_alusrc), .in_shift(in_shift),
        .in_aluop(in_aluop), .in_regwen(in_regwen),
        .exm_regwen(exm_regwen), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_regwen(mwb_regwen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .portA(portA), .portB(portB), .aluOp(aluOp), .out_valid(out_valid),
        .out_rd(out_rd), .out_regwen(out_regwen), .out_store_data(out_store_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsd,
                             input logic [31:0] rtd, input logic [31:0] imm,
                             input logic [4:0] sh, input logic asrc, input logic shf,
                             input logic [3:0] op, input logic wen);
        in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd;
        in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_shamt = sh;
        in_alusrc = asrc; in_shift = shf; in_aluop = op; in_regwen = wen;
    endtask

    task automatic no_fwd();
        exm_regwen = 0; exm_rd = 0; exm_data = 0;
        mwb_regwen = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    initial begin
        // Reset with a live instruction on the inputs
        RST = 1; en = 1; flush = 0;
        no_fwd();
        set_instr(1, 5'd8, 5'd4, 5'd6, 32'h11, 32'h22, 32'h33, 5'd2, 0, 0, 4'h3, 1);
        tick();
        chk("rst_portA", portA, 32'h0);
        chk("rst_portB", portB, 32'h0);
        chk("rst_aluOp", {28'd0, aluOp}, 32'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_rd", {27'd0, out_rd}, 32'h0);
        chk("rst_regwen", {31'd0, out_regwen}, 32'h0);
        chk("rst_store", out_store_data, 32'h0);

        RST = 0;
        tick();
        chk("post_rst_aluOp", {28'd0, aluOp}, 32'h3);

        // Basic pass, immediate on portB
        set_instr(1, 5'd8, 5'd2, 5'd8, 32'h10, 32'h55, 32'hFFFF_FFFC, 5'd0, 1, 0, 4'h2, 1);
        tick();
        chk("basic_portA", portA, 32'h10);
        chk("basic_portB", portB, 32'hFFFF_FFFC);
        chk("basic_store", out_store_data, 32'h55);
        chk("basic_valid", {31'd0, out_valid}, 32'h1);
        chk("basic_rd", {27'd0, out_rd}, 32'h8);
        chk("basic_regwen", {31'd0, out_regwen}, 32'h1);
        chk("basic_aluOp", {28'd0, aluOp}, 32'h2);

        // Shift operand, register on portB, invalid slot never writes
        set_instr(0, 5'd8, 5'd2, 5'd3, 32'h10, 32'h66, 32'h0, 5'd7, 0, 1, 4'h4, 1);
        tick();
        chk("shift_portA", portA, 32'h7);
        chk("shift_portB", portB, 32'h66);
        chk("invalid_regwen", {31'd0, out_regwen}, 32'h0);

        // Forward priority
        set_instr(1, 5'd9, 5'd9, 5'd1, 32'h1, 32'h2, 32'h0, 5'd0, 0, 0, 4'h1, 1);
        tick();
        exm_regwen = 1; exm_rd = 5'd9; exm_data = 32'hAAAA;
        mwb_regwen = 1; mwb_rd = 5'd9; mwb_data = 32'hBBBB;
        #1;
        chk("fwd_exm_portA", portA, 32'hAAAA);
        chk("fwd_exm_portB", portB, 32'hAAAA);
        chk("fwd_exm_store", out_store_data, 32'hAAAA);
        exm_regwen = 0;
        #1;
        chk("fwd_mwb_portA", portA, 32'hBBBB);
        chk("fwd_mwb_portB", portB, 32'hBBBB);
        chk("fwd_mwb_store", out_store_data, 32'hBBBB);
        mwb_regwen = 0;
        #1;
        chk("fwd_none_portA", portA, 32'h1);
        chk("fwd_none_portB", portB, 32'h2);

        // Register 0 never forwarded
        no_fwd();
        set_instr(1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h99, 32'h0, 5'd0, 0, 0, 4'h0, 0);
        tick();
        exm_regwen = 1; exm_rd = 5'd0; exm_data = 32'h1234;
        #1;
        chk("r0_portA", portA, 32'h0);
        chk("r0_portB", portB, 32'h99);

        // Stall refresh across three cycles
        no_fwd();
        set_instr(1, 5'd3, 5'd5, 5'd10, 32'h30, 32'h0, 32'h0, 5'd0, 0, 0, 4'h6, 1);
        tick();
        en = 0;
        set_instr(1, 5'd7, 5'd7, 5'd7, 32'hDEAD, 32'hDEAD, 32'hDEAD, 5'd1, 1, 1, 4'hF, 0);
        mwb_regwen = 1; mwb_rd = 5'd5; mwb_data = 32'h77;
        #1;
        chk("stall_c1_portB", portB, 32'h77);
        tick();
        mwb_regwen = 0;
        #1;
        chk("stall_c2_portB", portB, 32'h77);
        chk("stall_c2_rd", {27'd0, out_rd}, 32'hA);
        tick();
        chk("stall_c3_portB", portB, 32'h77);
        chk("stall_c3_portA", portA, 32'h30);
        chk("stall_c3_aluOp", {28'd0, aluOp}, 32'h6);

        // Reset mid-stall discards state and refresh
        mwb_regwen = 1;
        RST = 1;
        tick();
        RST = 0;
        mwb_regwen = 0;
        #1;
        chk("rst_stall_portB", portB, 32'h0);
        chk("rst_stall_valid", {31'd0, out_valid}, 32'h0);

        // Flush beats enable
        en = 1;
        set_instr(1, 5'd4, 5'd6, 5'd12, 32'h44, 32'h66, 32'h0, 5'd0, 0, 0, 4'h5, 1);
        tick();
        chk("preflush_valid", {31'd0, out_valid}, 32'h1);
        flush = 1;
        set_instr(1, 5'd4, 5'd6, 5'd13, 32'h45, 32'h67, 32'h0, 5'd0, 0, 0, 4'h7, 1);
        tick();
        flush = 0; en = 0;
        chk("flush_valid", {31'd0, out_valid}, 32'h0);
        chk("flush_regwen", {31'd0, out_regwen}, 32'h0);
        chk("flush_aluOp", {28'd0, aluOp}, 32'h0);
        chk("flush_portA", portA, 32'h0);
        chk("flush_portB", portB, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
